// File: rtl/adc_pkg.sv
// adc_pkg: shared states, frame layout constants and channel helpers for the ADC scanner.
package adc_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, FRAME, GAP} state_t;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_FIRST = 2;
    localparam int DATA_FIRST = 4;
    localparam int DATA_LAST  = 13;

    function automatic logic [2:0] low_idx(logic [7:0] m);
        logic [2:0] r = '0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) r = 3'(i);
        return r;
    endfunction

    // Address bits go out MSB first starting at ADDR_FIRST; every other bit is zero.
    function automatic logic din_bit(logic [3:0] idx, logic [2:0] ch);
        int k = ADDR_FIRST + 2 - int'(idx);
        return (k >= 0 && k <= 2) ? ch[2'(k)] : 1'b0;
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: SCLK generator; idles high, toggles every CLK_DIV clk cycles while enabled.
module adc_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    logic [7:0] cnt;
    logic       term;

    // Strobes mark the clk edge at which the registered sclk changes.
    assign term = cnt == 8'(CLK_DIV - 1);
    assign rise = term && !sclk;
    assign fall = term && sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (term) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: scans enabled ADC channels over back-to-back 16-bit serial frames,
// emitting one result per channel (results lag the addressed channel by one frame).
module adc_scan_ctrl
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic [7:0] ch_mask,
    output logic       busy,
    output logic       sclk,
    output logic       cs_n,
    output logic       din,
    input  logic       dout,
    output logic [9:0] data,
    output logic [2:0] data_ch,
    output logic       data_valid,
    output logic       scan_done
);

    state_t     state;
    logic [7:0] pend;
    logic [7:0] gap_cnt;
    logic [3:0] bit_idx;
    logic [2:0] cur_ch;
    logic [2:0] prev_ch;
    logic [9:0] shift;
    logic       first;
    logic       last;
    logic       grab;
    logic       rise;
    logic       fall;
    logic       sclk_en;
    logic       frame_end;
    logic       gap_done;
    logic       go;

    assign frame_end = state == FRAME && fall && bit_idx == 4'(FRAME_BITS - 1);
    assign gap_done  = gap_cnt == 8'(CS_GAP - 1);
    assign go        = ch_mask != 8'd0 && ((state == IDLE && start) || (state == GAP && gap_done && cont));
    // SETUP is the first high half-period; dropping enable on the final fall keeps sclk high.
    assign sclk_en   = state == SETUP || (state == FRAME && !(frame_end && last));

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk  (clk),
        .rst  (rst),
        .en   (sclk_en),
        .sclk (sclk),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cs_n       <= 1'b1;
            din        <= 1'b0;
            data       <= '0;
            data_ch    <= '0;
            data_valid <= 1'b0;
            scan_done  <= 1'b0;
            pend       <= '0;
            gap_cnt    <= '0;
            bit_idx    <= '0;
            cur_ch     <= '0;
            prev_ch    <= '0;
            shift      <= '0;
            first      <= 1'b0;
            last       <= 1'b0;
            grab       <= 1'b0;
        end else begin
            data_valid <= grab;
            scan_done  <= grab && last;
            grab       <= 1'b0;
            if (grab) begin
                data    <= shift;
                data_ch <= prev_ch;
            end
            if (go) begin
                state   <= SETUP;
                busy    <= 1'b1;
                cs_n    <= 1'b0;
                gap_cnt <= '0;
                cur_ch  <= low_idx(ch_mask);
                pend    <= ch_mask & (ch_mask - 8'd1);
                first   <= 1'b1;
                last    <= 1'b0;
            end else begin
                case (state)
                    SETUP: if (fall) begin
                        state   <= FRAME;
                        bit_idx <= '0;
                        din     <= 1'b0;
                    end
                    FRAME: begin
                        if (rise && bit_idx >= 4'(DATA_FIRST) && bit_idx <= 4'(DATA_LAST))
                            shift <= {shift[8:0], dout};
                        if (rise && bit_idx == 4'(DATA_LAST) && !first)
                            grab <= 1'b1;
                        if (frame_end) begin
                            bit_idx <= '0;
                            din     <= 1'b0;
                            if (last) begin
                                state   <= GAP;
                                cs_n    <= 1'b1;
                                gap_cnt <= '0;
                            end else begin
                                // Once every enabled channel is addressed, one extra frame on ch0 flushes the last result.
                                prev_ch <= cur_ch;
                                first   <= 1'b0;
                                cur_ch  <= low_idx(pend);
                                pend    <= pend & (pend - 8'd1);
                                last    <= pend == 8'd0;
                            end
                        end else if (fall) begin
                            bit_idx <= bit_idx + 4'd1;
                            din     <= din_bit(bit_idx + 4'd1, cur_ch);
                        end
                    end
                    GAP: if (gap_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: directed bench with an ADC model returning 10'h155 + addressed channel.
module tb_adc_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       dout = 1'b0;
    logic [7:0] ch_mask = 8'h00;
    logic       busy, sclk, cs_n, din, data_valid, scan_done;
    logic [9:0] data;
    logic [2:0] data_ch;

    int total = 0;
    int bad = 0;

    adc_scan_ctrl #(.CLK_DIV(4), .CS_GAP(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cont       (cont),
        .ch_mask    (ch_mask),
        .busy       (busy),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .din        (din),
        .dout       (dout),
        .data       (data),
        .data_ch    (data_ch),
        .data_valid (data_valid),
        .scan_done  (scan_done)
    );

    always #5 clk = ~clk;

    // ADC model: counts bits on sclk falls, captures address on rises, answers one frame later.
    int         m_bit = -1;
    int         frames = 0;
    logic [2:0] m_addr = 3'd0;
    logic [2:0] m_prev = 3'd0;
    logic [9:0] m_val;
    logic [2:0] addr_q[$];

    always @(negedge cs_n) m_bit = -1;

    always @(negedge sclk) if (!cs_n) begin
        m_bit = (m_bit == 15) ? 0 : m_bit + 1;
        if (m_bit == 0) begin
            m_prev = m_addr;
            frames++;
        end
        m_val = 10'h155 + 10'(m_prev);
        dout = (m_bit >= 4 && m_bit <= 13) ? m_val[13 - m_bit] : 1'b0;
    end

    always @(posedge sclk) if (!cs_n && m_bit >= 2 && m_bit <= 4) begin
        m_addr = {m_addr[1:0], din};
        if (m_bit == 4) addr_q.push_back(m_addr);
    end

    logic [12:0] dv_q[$];
    int sd_cnt = 0, sd_idx = 0, cs_low = 0, gap_cyc = 0, busy_cyc = 0, edges = 0;

    always @(sclk) edges++;

    always @(negedge clk) begin
        if (data_valid) dv_q.push_back({data_ch, data});
        if (scan_done) begin
            sd_cnt++;
            sd_idx = data_valid ? dv_q.size() : -1;
        end
        cs_low   += int'(!cs_n);
        gap_cyc  += int'(busy && cs_n);
        busy_cyc += int'(busy);
    end

    int b_dv, b_fr, b_sd, b_cs, b_gap, b_busy, b_ed, b_addr;

    task automatic snap();
        b_dv = dv_q.size(); b_fr = frames; b_sd = sd_cnt; b_cs = cs_low;
        b_gap = gap_cyc; b_busy = busy_cyc; b_ed = edges; b_addr = addr_q.size();
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dv(int i, logic [2:0] ch);
        logic [12:0] e;
        e = (b_dv + i < dv_q.size()) ? dv_q[b_dv + i] : 13'h1fff;
        chk("dv_ch", 32'(e[12:10]), 32'(ch));
        chk("dv_data", 32'(e[9:0]), 32'(10'h155 + 10'(ch)));
    endtask

    task automatic chk_addr(int i, logic [2:0] ch);
        logic [2:0] a;
        a = (b_addr + i < addr_q.size()) ? addr_q[b_addr + i] : 3'bxxx;
        chk("din_addr", 32'(a), 32'(ch));
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < budget), 32'd1);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sclk", 32'(sclk), 32'd1);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_data_ch", 32'(data_ch), 32'd0);
        chk("rst_dv", 32'(data_valid), 32'd0);
        chk("rst_done", 32'(scan_done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // two channels: frames address 0,2,0; results ch0 then ch2
        snap();
        ch_mask = 8'h05;
        pulse_start();
        chk("busy_on_accept", 32'(busy), 32'd1);
        wait_idle(2000);
        chk("m05_frames", 32'(frames - b_fr), 32'd3);
        chk_addr(0, 3'd0);
        chk_addr(1, 3'd2);
        chk_addr(2, 3'd0);
        chk("m05_results", 32'(dv_q.size() - b_dv), 32'd2);
        chk_dv(0, 3'd0);
        chk_dv(1, 3'd2);
        chk("m05_done_cnt", 32'(sd_cnt - b_sd), 32'd1);
        chk("m05_done_with_last", 32'(sd_idx - b_dv), 32'd2);
        chk("m05_cs_low", 32'(cs_low - b_cs), 32'(4 + 3 * 128));

        // single channel 7
        snap();
        ch_mask = 8'h80;
        pulse_start();
        wait_idle(2000);
        chk("m80_frames", 32'(frames - b_fr), 32'd2);
        chk("m80_results", 32'(dv_q.size() - b_dv), 32'd1);
        chk_dv(0, 3'd7);
        chk("m80_cs_low", 32'(cs_low - b_cs), 32'(4 + 2 * 128));
        chk("m80_gap", 32'(gap_cyc - b_gap), 32'd2);

        // empty mask is ignored
        snap();
        ch_mask = 8'h00;
        pulse_start();
        repeat (50) @(negedge clk);
        #1;
        chk("m00_busy", 32'(busy_cyc - b_busy), 32'd0);
        chk("m00_cs_low", 32'(cs_low - b_cs), 32'd0);
        chk("m00_sclk_edges", 32'(edges - b_ed), 32'd0);

        // restart and mask change mid-scan do not disturb the scan
        snap();
        ch_mask = 8'h05;
        pulse_start();
        repeat (20) @(negedge clk);
        ch_mask = 8'hF0;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (200) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_idle(2000);
        chk("mid_frames", 32'(frames - b_fr), 32'd3);
        chk_addr(1, 3'd2);
        chk("mid_results", 32'(dv_q.size() - b_dv), 32'd2);
        chk_dv(0, 3'd0);
        chk_dv(1, 3'd2);

        // continuous scanning of all channels, two scans
        snap();
        ch_mask = 8'hFF;
        cont = 1'b1;
        pulse_start();
        n = 0;
        while (sd_cnt < b_sd + 1 && n < 3000) begin @(negedge clk); n++; end
        while (!cs_n && n < 3000) begin @(negedge clk); n++; end
        while (cs_n && n < 3000) begin @(negedge clk); n++; end
        chk("cont_rescan", 32'(n < 3000), 32'd1);
        cont = 1'b0;
        wait_idle(2000);
        chk("cont_frames", 32'(frames - b_fr), 32'd18);
        chk("cont_results", 32'(dv_q.size() - b_dv), 32'd16);
        for (int i = 0; i < 16; i++) chk_dv(i, 3'(i % 8));
        chk("cont_done_cnt", 32'(sd_cnt - b_sd), 32'd2);
        chk("cont_gap", 32'(gap_cyc - b_gap), 32'd4);
        chk("cont_cs_low", 32'(cs_low - b_cs), 32'(2 * (4 + 9 * 128)));

        // asynchronous reset at frame 1, bit 7
        snap();
        ch_mask = 8'h05;
        pulse_start();
        n = 0;
        while (!(frames - b_fr == 2 && m_bit == 7) && n < 2000) begin @(negedge clk); n++; end
        chk("abort_reach", 32'(n < 2000), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_cs_n", 32'(cs_n), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (400) @(negedge clk);
        #1;
        chk("abort_results", 32'(dv_q.size() - b_dv), 32'd0);
        chk("abort_done", 32'(sd_cnt - b_sd), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
